// File: rtl/fp754_pkg.sv
// fp754_pkg: shared state encoding and IEEE-754 single-precision constants.
package fp754_pkg;
    typedef enum logic [2:0] {IDLE, CHECK, MULT, NORM, DONE} state_t;
    localparam int          BIAS    = 127;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FFFFFFF;
    localparam logic [31:0] ZERO    = 32'h00000000;
    // Magnitude part of an infinity; prepend the sign bit to build +/-Inf.
    localparam logic [30:0] INF_MAG = {EXP_MAX, 23'h0};
endpackage

// File: rtl/specialcase.sv
// specialcase: classifies one single-precision operand as Zero, Inf or NaN (denormals count as Zero).
module specialcase
    import fp754_pkg::*;
(
    input  logic [31:0] I,
    output logic        Inf,
    output logic        NaN,
    output logic        Zero
);
    logic unused_sign;
    assign unused_sign = I[31];
    assign Zero = I[30:23] == 8'h00;
    assign Inf  = I[30:23] == EXP_MAX && I[22:0] == 23'h0;
    assign NaN  = I[30:23] == EXP_MAX && I[22:0] != 23'h0;
endmodule

// File: rtl/fpmul_seq_ctrl.sv
// fpmul_seq_ctrl: sequential shift-add single-precision multiplier with fixed latency and truncation.
module fpmul_seq_ctrl
    import fp754_pkg::*;
#(
    parameter logic [31:0] NAN_CODE = QNAN,
    parameter int          MANT_W   = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    localparam int CNT_W = $clog2(MANT_W);
    localparam int P_W   = 2 * MANT_W;

    state_t                 state, next;
    logic [31:0]            a_q, b_q, result_q;
    logic [P_W-1:0]         acc;
    logic [MANT_W-1:0]      mplier, mcand;
    logic [CNT_W-1:0]       cnt;
    logic [9:0]             exp_q, exp_n;
    logic                   a_inf, a_nan, a_zero, b_inf, b_nan, b_zero;
    logic                   special, sign, last;
    logic [31:0]            spec_res, norm_res;
    logic [MANT_W-2:0]      mant_n;

    specialcase u_sc_a (.I(a_q), .Inf(a_inf), .NaN(a_nan), .Zero(a_zero));
    specialcase u_sc_b (.I(b_q), .Inf(b_inf), .NaN(b_nan), .Zero(b_zero));

    assign sign     = a_q[31] ^ b_q[31];
    assign special  = a_inf | a_nan | a_zero | b_inf | b_nan | b_zero;
    assign spec_res = (a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero)) ? NAN_CODE :
                      (a_zero | b_zero) ? ZERO : {sign, INF_MAG};
    assign last     = cnt == CNT_W'(MANT_W - 1);

    // Top product bit set means the significand product landed in [2,4).
    assign mant_n   = acc[P_W-1] ? acc[P_W-2 -: MANT_W-1] : acc[P_W-3 -: MANT_W-1];
    assign exp_n    = exp_q + (acc[P_W-1] ? 10'd1 : 10'd0);
    assign norm_res = ($signed(exp_n) >= 10'sd255) ? {sign, INF_MAG} :
                      ($signed(exp_n) <= 10'sd0)   ? ZERO : {sign, exp_n[7:0], mant_n};

    assign busy   = state != IDLE;
    assign done   = state == DONE;
    assign result = result_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? CHECK : IDLE;
            CHECK:   next = special ? DONE : MULT;
            MULT:    next = last ? NORM : MULT;
            NORM:    next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= ZERO;
            acc      <= '0;
            mplier   <= '0;
            mcand    <= '0;
            cnt      <= '0;
            exp_q    <= '0;
        end else if (state == IDLE && start) begin
            a_q <= in1;
            b_q <= in2;
        end else if (state == CHECK && special) begin
            result_q <= spec_res;
        end else if (state == CHECK) begin
            acc    <= '0;
            mplier <= {1'b1, a_q[MANT_W-2:0]};
            mcand  <= {1'b1, b_q[MANT_W-2:0]};
            exp_q  <= {2'b00, a_q[30:23]} + {2'b00, b_q[30:23]} - 10'(BIAS);
            cnt    <= '0;
        end else if (state == MULT) begin
            if (mplier[0]) acc <= acc + ({{MANT_W{1'b0}}, mcand} << cnt);
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end else if (state == NORM) begin
            result_q <= norm_res;
        end
    end
endmodule

// File: tb/tb_fpmul_seq_ctrl.sv
// tb_fpmul_seq_ctrl: directed vector table plus hand sequences for ignored start and mid-run reset.
module tb_fpmul_seq_ctrl;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] in1 = '0, in2 = '0;
    logic        busy, done;
    logic [31:0] result;
    int          errs = 0, checks = 0;

    fpmul_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Latch edge is cycle 0; a done seen after n further edges is cycle n+1.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in1 = $urandom; in2 = $urandom;
        chk("busy_cycle1", {31'b0, busy}, 32'd1);
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (done) lat = n + 1;
        end
        res = result;
        @(posedge clk); #1;
        chk("done_width", {31'b0, done}, 32'd0);
        chk("busy_after", {31'b0, busy}, 32'd0);
        chk("result_held", result, res);
    endtask

    logic [31:0] res;
    int          lat, dn;

    initial begin
        vecs[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 27};
        vecs[1] = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 27};
        vecs[2] = '{32'h00000000, 32'h7F800000, 32'h7FFFFFFF, 2};
        vecs[3] = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 2};
        vecs[4] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 27};
        vecs[5] = '{32'h00800000, 32'h00800000, 32'h00000000, 27};
        vecs[6] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 27};
        vecs[7] = '{32'h7FC00000, 32'h3F800000, 32'h7FFFFFFF, 2};
        vecs[8] = '{32'h40000000, 32'h80000000, 32'h00000000, 2};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].r);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // A second start in cycle 10 must be ignored.
        in1 = 32'h3FC00000; in2 = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk); #1;
            start = (n == 9);
            in1 = 32'h40400000; in2 = 32'h40400000;
            if (done) lat = n + 1;
        end
        start = 1'b0;
        chk("ignored_start_result", result, 32'h40400000);
        chk("ignored_start_latency", 32'(lat), 32'd27);
        @(posedge clk); #1;
        chk("ignored_start_idle", {31'b0, busy}, 32'd0);

        // Reset in cycle 12 aborts the operation without a done pulse.
        in1 = 32'h3FC00000; in2 = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_result", result, 32'h0);
        chk("abort_done", {31'b0, done}, 32'd0);
        dn = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        run_op(32'h3FC00000, 32'h40000000, res, lat);
        chk("after_abort_result", res, 32'h40400000);
        chk("after_abort_latency", 32'(lat), 32'd27);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/fpmul_seq_ctrl.md
FPMUL_SEQ_CTRL -- requirements
Module: fpmul_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 Parameter NAN_CODE SHALL default to 32'h7FFFFFFF and SHALL be the NaN result pattern.
REQ-003 Parameter MANT_W SHALL default to 24 and SHALL be the significand width including the hidden bit; it SHALL also be the iteration count.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: request; sampled only in IDLE.
- in1, in, 32: IEEE-754 single operand A.
- in2, in, 32: IEEE-754 single operand B.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse when result is valid.
- result, out, 32: product, held until the next accepted start.

Function
REQ-005 The FSM SHALL have the states IDLE, CHECK, MULT, NORM and DONE.
REQ-006 In IDLE with start=1, the block SHALL latch in1 and in2 and enter CHECK. Call this edge cycle 0.
REQ-007 start SHALL be ignored whenever busy=1, and operand changes after the latch edge SHALL have no effect.
REQ-008 CHECK (cycle 1) SHALL classify each latched operand into exactly one class:
- Zero: exponent 0, including denormals (flushed to zero).
- Inf: exponent FF, mantissa 0.
- NaN: exponent FF, mantissa not 0.
- Normal: any other encoding.
REQ-009 If either operand is special, CHECK SHALL load result directly and enter DONE, giving done in cycle 2. The special results are:
- Either operand NaN: NAN_CODE.
- Zero×Inf (either order): NAN_CODE.
- Zero×Zero or Zero×Normal: 32'h00000000.
- Inf×Inf or Inf×Normal: sign = in1[31]^in2[31], exponent FF, mantissa 0.
REQ-010 If neither operand is special, CHECK SHALL do the following, then enter MULT:
- Clear the 48-bit accumulator.
- Load the multiplier register with {1,mantA} and the multiplicand with {1,mantB}.
- Compute the 10-bit signed exponent expA+expB-127.
- Clear the iteration counter.
REQ-011 MULT SHALL perform one shift-add step per cycle for exactly MANT_W cycles (cycles 2..25):
- If the multiplier LSB is 1, add the multiplicand shifted left by the counter value to the accumulator.
- Shift the multiplier right by one.
- Increment the counter.
- Leave MULT after the counter reaches MANT_W-1.
REQ-012 NORM (cycle 26) SHALL normalize the product P[47:0]:
- If P[47]=1: mantissa = P[46:24], exponent +1.
- Otherwise: mantissa = P[45:23].
- Rounding SHALL be truncation.
REQ-013 After normalization, NORM SHALL apply the exponent range rules:
- Exponent ≥ 255: result SHALL be signed Inf.
- Exponent ≤ 0: result SHALL be 32'h00000000.
- Otherwise: result SHALL be {sign, exp[7:0], mantissa}.
REQ-014 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-015 Normal-path latency SHALL be fixed: done in cycle 27. Special-path latency SHALL be done in cycle 2.
REQ-016 A start that is high in the same cycle DONE returns to IDLE SHALL NOT be accepted until the block is in IDLE. Back-to-back throughput SHALL therefore be one operation per 28 cycles (normal path).
REQ-017 result SHALL change only on the cycle done rises, or on reset.

Reset
REQ-018 On rst=1 at a rising edge, the block SHALL set state=IDLE, busy=0, done=0, result=32'h00000000, and clear the accumulator, counter and operand registers.
REQ-019 Reset mid-operation (any state) SHALL abort the operation with no done pulse. The block SHALL accept start on the first edge after rst deasserts.
REQ-020 rst SHALL take priority over start in the same cycle.

Structure
REQ-021 Shared package fp754_pkg SHALL hold:
- The state encoding.
- The constants BIAS=127, EXP_MAX=8'hFF, QNAN=32'h7FFFFFFF and ZERO=32'h00000000.
- The Inf-building helper constant.
REQ-022 Operand classification SHALL use two instances of the existing specialcase sub-module (ports I, Inf, NaN, Zero). No other sub-module SHALL be used.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- in1=3FC00000 (1.5), in2=40000000 (2.0), start pulse -> busy from cycle 1, done only in cycle 27, result=40400000.
- in1=C0000000 (-2), in2=40400000 (3) -> result=C0C00000 in cycle 27; done width exactly 1 cycle.
- in1=00000000, in2=7F800000 -> result=7FFFFFFF, done in cycle 2. Also in1=FF800000, in2=3F800000 -> FF800000, done in cycle 2.
- in1=7F000000, in2=7F000000 -> 7F800000. in1=00800000, in2=00800000 -> 00000000.
- Second start pulse with different operands at cycle 10 -> ignored; result equals the first operation's result.
- rst asserted in cycle 12 (MULT) -> no done pulse, result=00000000, busy=0 next cycle. A new start 1.5×2.0 afterwards -> 40400000 after 27 cycles.
